top_v: RTL and testbench
========================

TOP_V -- requirements
Module: top_v

Interface
REQ-001 Parameter WIDTH, default 1, data width of d and q (legal range 1..64).
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits), value loaded into q on reset.
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  WIDTH-independent 1  load enable; when high, d is captured on the next rising clk edge.
REQ-006 d  input  WIDTH  data to be captured.
REQ-007 q  output  WIDTH  registered data; driven directly from flip-flops with no combinational path from any input.

Function
REQ-008 On a rising clk edge with rst_n high and en high, q SHALL take the value d held at that edge.
REQ-009 On a rising clk edge with rst_n high and en low, q SHALL hold its previous value regardless of d.
REQ-010 Latency SHALL be exactly one clock edge from d/en sampled to q updated; q SHALL never follow d combinationally.
REQ-011 d and en SHALL be sampled only at the rising clk edge; changes between edges SHALL have no effect on q.
REQ-012 If en is high for consecutive edges, q SHALL track d edge-by-edge (a one-cycle delayed copy of d).
REQ-013 All WIDTH bits SHALL share the single en; no per-bit enable and no partial update.
REQ-014 With en low from reset onward, q SHALL remain RESET_VALUE indefinitely, even if d toggles.
REQ-015 X or Z on d while en is low SHALL NOT propagate to q.

Reset
REQ-016 When rst_n falls, q SHALL take RESET_VALUE immediately, without waiting for a clk edge.
REQ-017 While rst_n is low, q SHALL stay RESET_VALUE, and clk, en and d SHALL be ignored.
REQ-018 On rst_n rising, the first capture SHALL occur at the first rising clk edge where rst_n is high and en is high.
REQ-019 Reset asserted mid-operation SHALL discard the held value; no earlier data SHALL reappear after reset release.
REQ-020 The reset polarity and asynchronous behaviour SHALL NOT be parameterisable.

Structure
REQ-021 No shared package is required; WIDTH and RESET_VALUE are module parameters only.
REQ-022 One sub-module, en_dff_bit (a single-bit enabled flip-flop with asynchronous active-low reset and a reset-value input), SHALL be instantiated WIDTH times via a generate loop.
REQ-023 Each en_dff_bit instance SHALL take its reset value from the corresponding bit of RESET_VALUE.
REQ-024 The design SHALL contain no latches, no gated clocks and no clock-enable implemented by clock gating; the enable SHALL be a data-path mux.

Verification
REQ-025 Hold with enable low: WIDTH=1, release rst_n, en=0, d=0 for 2 edges, then d=1 for 3 edges -> q=0 throughout.
REQ-026 Enable capture: en=1 with d=0, then d=1 applied before the next edge -> q=0 after the first edge and q=1 after the following edge, never earlier.
REQ-027 Enable drop: en=1, d=1 for one edge (q=1), then en=0 and d=0 for 4 edges -> q stays 1.
REQ-028 Async reset: q=1, assert rst_n=0 midway between clk edges -> q=0 before the next edge; q holds 0 while rst_n is low, even with en=1 and d=1.
REQ-029 Width and reset value: WIDTH=8, RESET_VALUE=8'hA5 -> q=8'hA5 out of reset; en=1 with d=8'h3C -> q=8'h3C after one edge; en=0 with d=8'hFF -> q stays 8'h3C.
REQ-030 Tracking: en=1, d sequence 0,1,1,0,1 on successive edges -> q shows the same sequence delayed by exactly one edge.

Source files
------------

// File: rtl/top_v_pkg.sv
// ============================================================================
// Module   : top_v_pkg
// Purpose  : Shared constants for the enabled data register slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package top_v_pkg;

    // Widest data path the register is qualified for.
    localparam int unsigned MAX_WIDTH = 64;

endpackage : top_v_pkg

`default_nettype wire

// File: rtl/top_v_en_dff_bit.sv
// ============================================================================
// Module   : en_dff_bit
// Purpose  : Single-bit flop with a data-path load enable and an async
//            active-low reset that loads rst_val.
// Revision : 1.0
// ============================================================================
`default_nettype none

module en_dff_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    // The enable selects between d and the current q; the clock is never gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : en_dff_bit

`default_nettype wire

// File: rtl/top_v.sv
// ============================================================================
// Module   : top_v
// Purpose  : WIDTH-bit enabled data register built from en_dff_bit slices,
//            with a per-bit reset value taken from RESET_VALUE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module top_v
    import top_v_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_width_check
        $error("top_v: WIDTH out of supported range");
    end

    // One shared enable drives every slice, so a load is always all-or-nothing.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        en_dff_bit u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .d       (d[i]),
            .rst_val (RESET_VALUE[i]),
            .q       (q[i])
        );
    end

endmodule : top_v

`default_nettype wire

// File: tb/tb_top_v.sv
// ============================================================================
// Module   : tb_top_v
// Purpose  : Directed self-checking bench for top_v (1-bit and 8-bit builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_top_v;

    logic       clk;
    logic       rst_n;
    logic       en1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       en8;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_checks = 0;
    int n_fail   = 0;

    top_v #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en1),
        .d     (d1),
        .q     (q1)
    );

    top_v #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en8),
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] seq;
        seq = 5'b10110;

        rst_n = 1'b0;
        en1   = 1'b0;
        d1    = 1'b0;
        en8   = 1'b0;
        d8    = 8'h00;
        tick();
        tick();
        check("reset_q1", 64'(q1), 64'h0);
        check("reset_q8", 64'(q8), 64'hA5);

        // Reset dominates clock, enable and data.
        en1 = 1'b1; d1 = 1'b1;
        en8 = 1'b1; d8 = 8'hFF;
        tick();
        check("rst_ignores_en_q1", 64'(q1), 64'h0);
        check("rst_ignores_en_q8", 64'(q8), 64'hA5);
        en1 = 1'b0; d1 = 1'b0;
        en8 = 1'b0; d8 = 8'h00;

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_q8", 64'(q8), 64'hA5);

        // Hold with enable low.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_d0", 64'(q1), 64'h0);
        end
        d1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_d1", 64'(q1), 64'h0);
        end

        // Enable capture with one-edge latency.
        en1 = 1'b1; d1 = 1'b0;
        tick();
        check("cap_first", 64'(q1), 64'h0);
        d1 = 1'b1;
        #2;
        check("cap_no_comb", 64'(q1), 64'h0);
        tick();
        check("cap_second", 64'(q1), 64'h1);

        // Enable drop keeps the captured value.
        en1 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("en_drop_hold", 64'(q1), 64'h1);
        end

        // Unknown data while disabled must not leak.
        d1 = 1'bx;
        tick();
        check("x_blocked", 64'(q1), 64'h1);

        // Width and reset value on the 8-bit build.
        en8 = 1'b1; d8 = 8'h3C;
        tick();
        check("w8_capture", 64'(q8), 64'h3C);
        en8 = 1'b0; d8 = 8'hFF;
        tick();
        check("w8_hold_a", 64'(q8), 64'h3C);
        tick();
        check("w8_hold_b", 64'(q8), 64'h3C);

        // Mid-cycle data change while enabled is only seen at the edge.
        en1 = 1'b1; d1 = 1'b0;
        tick();
        check("sample_edge", 64'(q1), 64'h0);
        d1 = 1'b1;
        #3;
        check("between_edges", 64'(q1), 64'h0);

        // Asynchronous reset between edges.
        tick();
        check("pre_reset_q1", 64'(q1), 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_q1", 64'(q1), 64'h0);
        check("async_q8", 64'(q8), 64'hA5);
        en8 = 1'b1;
        tick();
        check("rst_hold_q1", 64'(q1), 64'h0);
        check("rst_hold_q8", 64'(q8), 64'hA5);
        en1 = 1'b0; en8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("no_stale_q1", 64'(q1), 64'h0);
        check("no_stale_q8", 64'(q8), 64'hA5);

        // Tracking: sequence 0,1,1,0,1 (seq bit 0 first).
        en1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d1 = seq[i];
            tick();
            check("track", 64'(q1), 64'(seq[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_top_v

`default_nettype wire
